ps2_scancode_framer: RTL and testbench
======================================

Name: ps2_scancode_framer

Overview:
- Upstream stage of the scancode-to-Spectrum translator.
- Samples the raw PS/2 clock and data lines and deserialises 11-bit device-to-host frames.
- Strips the E0, F0 and E1 prefixes and drops protocol bytes.
- Delivers one single-cycle scan_received pulse per make or break event, together with a held scan, extended and released.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2clk samples required before the filtered clock changes (2..255)
TIMEOUT_CYCLES, 20000, clk cycles without a filtered ps2clk falling edge before a partial frame is aborted (16-bit counter)

Ports:
clk  input  1  system clock, same clock as the downstream translator
rst  input  1  asynchronous, active-low reset
ps2clk  input  1  raw PS/2 clock line, asynchronous
ps2data  input  1  raw PS/2 data line, asynchronous
scan_received  output  1  one-cycle pulse: new key event
scan  output  8  scancode without prefixes; held until the next pulse
extended  output  1  event was E0-prefixed; held
released  output  1  event was F0-prefixed (break); held
parity_error  output  1  one-cycle pulse: frame rejected for bad parity or bad stop bit
frame_timeout  output  1  one-cycle pulse: partial frame aborted

Behaviour:
Reset (rst=0, asynchronous):
- All outputs go to 0.
- FSM goes to RX_IDLE.
- Prefix flags, skip counter and timeout counter are cleared.
- Filtered clock and synchronisers are set to 1.

Input conditioning:
- Each line passes through a 2-flop synchroniser.
- ps2clk then passes through the FILTER_LEN deglitcher.
- A falling edge of the filtered clock is a one-cycle strobe "fe".
- ps2data (synchronised) is sampled at fe.

Bit receiver FSM:
- RX_IDLE: fe with data=0 -> RX_DATA, bitcnt=0. fe with data=1 -> ignored.
- RX_DATA: shifts data in LSB first at each fe. After the 8th bit -> RX_PARITY.
- RX_PARITY: at fe, stores the parity bit -> RX_STOP.
- RX_STOP: at fe, the frame is good if the count of ones over the 8 data bits plus parity is odd and stop=1.
  - Good frame: byte_valid is internal and asserted in the next cycle.
  - Bad frame: parity_error pulses in the next cycle and the prefix flags and skip counter are cleared.
  - Either way -> RX_IDLE.
- Timeout: the counter clears on every fe and in RX_IDLE. When it reaches TIMEOUT_CYCLES-1 outside RX_IDLE:
  - go to RX_IDLE;
  - pulse frame_timeout;
  - clear the prefix flags and skip counter.
  - If a timeout and an fe occur in the same cycle, the fe wins and there is no timeout.

Prefix layer (acts on byte_valid; rules in priority order):
1. skip counter > 0: decrement it; discard the byte.
2. E1: skip counter = 7; clear ext_pend and rel_pend; discard. A Pause sequence is fully suppressed.
3. E0: ext_pend=1.
4. F0: rel_pend=1.
5. 00, FF (overrun), AA (BAT), FA, FE, EE: discard; clear ext_pend and rel_pend.
6. Any other byte, in the next cycle:
   - scan=byte, extended=ext_pend, released=rel_pend;
   - scan_received=1 for exactly one cycle;
   - clear the flags.

Ordering and latency:
- E0 F0 and F0 E0 orders are both accepted.
- Repeated prefixes are idempotent.
- E0 12 and E0 59 (fake shifts) are forwarded as ordinary extended events.
- Latency: fe of the stop bit in cycle N -> byte_valid in N+1 -> scan_received in N+2.
- scan, extended and released change only in the cycle scan_received is high.

Overlap and stability:
- No pulse overlaps another.
- Minimum spacing between scan_received pulses is one PS/2 frame.
- A glitch on ps2clk shorter than FILTER_LEN clk cycles produces no fe.
- The host never drives the lines. This block is receive-only.

Test Plan:
1. Frame 0x1C (start 0, data LSB first, parity 0, stop 1) -> scan_received pulse exactly 2 clk after the stop fe; scan=1C, extended=0, released=0.
2. Frames F0, 1C -> exactly one pulse; scan=1C, released=1, extended=0. The F0 byte alone produces no pulse.
3. Frames E0, F0, 75, then separately F0, E0, 6B -> two pulses: {75,ext=1,rel=1} and {6B,ext=1,rel=1}.
4. Frame E0, then 0x1C with parity bit 1 -> parity_error pulse with no scan_received. A following good 0x29 yields scan=29 with extended=0, showing the prefix was cleared.
5. Sequence E1 14 77 E1 F0 14 F0 77, then 1C -> no scan_received during the Pause sequence; exactly one pulse with scan=1C, ext=0, rel=0.
6. Five bits of a frame then idle for TIMEOUT_CYCLES -> frame_timeout pulse and FSM in RX_IDLE. Then:
   - a ps2clk low glitch of FILTER_LEN-1 cycles -> no effect;
   - a full 0x29 frame -> scan=29;
   - asserting rst mid-frame -> all outputs 0 at once, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_framer.sv
// PS/2 device-to-host receiver: synchronises and deglitches the lines, deserialises
// 11-bit frames and strips E0/F0/E1 prefixes into single make/break events.
module ps2_scancode_framer #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       scan_received,
    output logic [7:0] scan,
    output logic       extended,
    output logic       released,
    output logic       parity_error,
    output logic       frame_timeout
);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        clk_meta_q, clk_sync_q;
    logic        dat_meta_q, dat_sync_q;
    logic        filt_q, filt_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        fe;

    rx_state_t   state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_q, byte_d;
    logic        perr_q, perr_d;
    logic        tout_q, tout_d;

    logic        ext_pend_q, ext_pend_d;
    logic        rel_pend_q, rel_pend_d;
    logic [2:0]  skip_q, skip_d;
    logic [7:0]  scan_q, scan_d;
    logic        ext_q, ext_d;
    logic        rel_q, rel_d;
    logic        srx_q, srx_d;

    // Deglitcher: the filtered clock only follows the synchronised line after
    // FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    assign fe = filt_q & ~filt_d;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        perr_d       = 1'b0;
        tout_d       = 1'b0;
        tcnt_d       = tcnt_q + 16'd1;
        if (state_q == RX_IDLE || fe) begin
            tcnt_d = '0;
        end

        case (state_q)
            RX_IDLE: begin
                if (fe && !dat_sync_q) begin
                    state_d  = RX_DATA;
                    bitcnt_d = '0;
                end
            end
            RX_DATA: begin
                if (fe) begin
                    shift_d  = {dat_sync_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fe) begin
                    par_d   = dat_sync_q;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fe) begin
                    // Odd parity over data+parity and a high stop bit.
                    if ((^{shift_q, par_q}) && dat_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // An edge arriving on the deadline cycle keeps the frame alive.
        if (state_q != RX_IDLE && !fe && tcnt_q == TOUT_LAST) begin
            state_d = RX_IDLE;
            tout_d  = 1'b1;
        end
    end

    always_comb begin
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        skip_d     = skip_q;
        scan_d     = scan_q;
        ext_d      = ext_q;
        rel_d      = rel_q;
        srx_d      = 1'b0;

        if (perr_q || tout_q) begin
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
            skip_d     = '0;
        end else if (byte_valid_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (byte_q)
                    // Pause: E1 plus the seven bytes that follow are swallowed.
                    8'hE1: begin
                        skip_d     = 3'd7;
                        ext_pend_d = 1'b0;
                        rel_pend_d = 1'b0;
                    end
                    8'hE0: ext_pend_d = 1'b1;
                    8'hF0: rel_pend_d = 1'b1;
                    8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
                        ext_pend_d = 1'b0;
                        rel_pend_d = 1'b0;
                    end
                    default: begin
                        scan_d     = byte_q;
                        ext_d      = ext_pend_q;
                        rel_d      = rel_pend_q;
                        srx_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        rel_pend_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            state_q      <= RX_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tcnt_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            perr_q       <= 1'b0;
            tout_q       <= 1'b0;
            ext_pend_q   <= 1'b0;
            rel_pend_q   <= 1'b0;
            skip_q       <= '0;
            scan_q       <= '0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            srx_q        <= 1'b0;
        end else begin
            clk_meta_q   <= ps2clk;
            clk_sync_q   <= clk_meta_q;
            dat_meta_q   <= ps2data;
            dat_sync_q   <= dat_meta_q;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tcnt_q       <= tcnt_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            perr_q       <= perr_d;
            tout_q       <= tout_d;
            ext_pend_q   <= ext_pend_d;
            rel_pend_q   <= rel_pend_d;
            skip_q       <= skip_d;
            scan_q       <= scan_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            srx_q        <= srx_d;
        end
    end

    assign scan_received = srx_q;
    assign scan          = scan_q;
    assign extended      = ext_q;
    assign released      = rel_q;
    assign parity_error  = perr_q;
    assign frame_timeout = tout_q;

endmodule

// File: tb/tb_ps2_scancode_framer.sv
// Bench for ps2_scancode_framer: bit-level PS/2 driver, byte-level prefix model.
module tb_ps2_scancode_framer;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic       scan_received;
    logic [7:0] scan;
    logic       extended;
    logic       released;
    logic       parity_error;
    logic       frame_timeout;

    always #5 clk = ~clk;

    ps2_scancode_framer #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2clk       (ps2clk),
        .ps2data      (ps2data),
        .scan_received(scan_received),
        .scan         (scan),
        .extended     (extended),
        .released     (released),
        .parity_error (parity_error),
        .frame_timeout(frame_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Events packed as {extended, released, scan}
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int obs_perr = 0, exp_perr = 0;
    int obs_tout = 0, exp_tout = 0;
    int hold_viol = 0, overlap_viol = 0;

    // Byte-level reference model of the prefix rules
    bit m_ext = 0, m_rel = 0;
    int m_skip = 0;

    task automatic model_clear();
        m_ext = 0; m_rel = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_perr++;
            model_clear();
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else if (b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE}) begin
            m_ext = 0; m_rel = 0;
        end else begin
            exp_q.push_back({m_ext, m_rel, b});
            m_ext = 0; m_rel = 0;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2data = b;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(!bad_stop);
        ps2data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        model_byte(b, !(bad_par || bad_stop));
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        check({tag, "_perr"}, obs_perr, exp_perr);
        check({tag, "_tout"}, obs_tout, exp_tout);
    endtask

    // Output monitor: records events, checks fe-to-pulse latency and hold behaviour
    initial begin
        int since_fe;
        logic [9:0] prev_out;
        since_fe = 100;
        prev_out = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                since_fe = 100;
                prev_out = '0;
            end else begin
                if (dut.fe) since_fe = 0;
                else if (since_fe < 100) since_fe++;
                if (scan_received) begin
                    check("latency", since_fe, 2);
                    obs_q.push_back({extended, released, scan});
                end else if ({extended, released, scan} != prev_out) begin
                    hold_viol++;
                end
                if (parity_error) obs_perr++;
                if (frame_timeout) obs_tout++;
                if (int'(scan_received) + int'(parity_error) + int'(frame_timeout) > 1)
                    overlap_viol++;
                prev_out = {extended, released, scan};
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] discards [6];
        discards = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {22'd0, scan_received, scan, extended, released}, 32'd0);
        check("rst_pulses", {30'd0, parity_error, frame_timeout}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h1C);
        compare_events("t1_plain");

        send_frame(8'hF0);
        check("t2_f0_alone", obs_q.size(), 0);
        send_frame(8'h1C);
        compare_events("t2_break");

        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        send_frame(8'hF0); send_frame(8'hE0); send_frame(8'h6B);
        compare_events("t3_ext_break");

        send_frame(8'hE0);
        send_frame(8'h1C, 1'b1);
        check("t4_no_event", obs_q.size(), 0);
        send_frame(8'h29);
        compare_events("t4_parity");

        send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
        send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
        check("t5_pause_silent", obs_q.size(), 0);
        send_frame(8'h1C);
        compare_events("t5_pause");

        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] b;
            bit bad;
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = discards[$urandom_range(0, 5)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 9) == 0);
            if (bad && $urandom_range(0, 1) == 1) send_frame(b, 1'b0, 1'b1);
            else send_frame(b, bad, 1'b0);
        end
        compare_events("rand");

        send_frame(8'hE0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2data = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk);
        exp_tout++;
        model_clear();
        compare_events("t6_timeout");

        ps2data = 1'b0;
        ps2clk  = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        repeat (100) @(negedge clk);
        send_frame(8'h29);
        compare_events("t6_glitch_then_29");

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        #1;
        check("t7_rst_outs", {22'd0, scan_received, scan, extended, released}, 32'd0);
        check("t7_rst_pulses", {30'd0, parity_error, frame_timeout}, 32'd0);
        repeat (3) @(negedge clk);
        ps2data = 1'b1;
        rst = 1'b1;
        model_clear();
        repeat (5) @(negedge clk);
        send_frame(8'hE0);
        send_frame(8'h5A);
        compare_events("t7_after_rst");

        check("hold_violations", hold_viol, 0);
        check("pulse_overlaps", overlap_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
